// File: rtl/timer_pkg.sv
// Shared constants and state encoding for the countdown timer stages.
package timer_pkg;

    localparam int TIME_W  = 6;
    localparam int SEC_MAX = 59;

    localparam logic [1:0] S_SET  = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    typedef enum logic [1:0] {
        ST_SET  = S_SET,
        ST_LOAD = S_LOAD,
        ST_RUN  = S_RUN,
        ST_DONE = S_DONE
    } timer_state_t;

endpackage

// File: rtl/edge_detect_sync.sv
// Registered rising-edge detector: rise is high for the cycle where level is
// high but was low at the previous edge.
module edge_detect_sync (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic rise
);

    logic level_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level;
        end
    end

    assign rise = level & ~level_q;

endmodule

// File: rtl/seconds_counter_s.sv
// Seconds stage of the countdown timer: presettable in set mode, counts down
// once per 1 Hz edge in run mode, borrowing from the minutes stage.
module seconds_counter_s
    import timer_pkg::*;
#(
    parameter int WIDTH     = TIME_W,
    parameter int MAX_COUNT = SEC_MAX
) (
    input  logic             clk_1Hz,
    input  logic             reset,
    input  logic             enable,
    input  logic             forward,
    input  logic             increment,
    input  logic [WIDTH-1:0] minutes,
    output logic [WIDTH-1:0] out,
    output logic             done,
    output logic             running
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);

    timer_state_t     state, state_next;
    logic [WIDTH-1:0] preset, preset_next;
    logic [WIDTH-1:0] count, count_next;
    logic [WIDTH-1:0] out_next;
    logic             inc_rise;

    edge_detect_sync u_inc_edge (
        .clk   (clk_1Hz),
        .reset (reset),
        .level (increment),
        .rise  (inc_rise)
    );

    always_ff @(posedge clk_1Hz) begin
        if (!reset) begin
            state  <= ST_SET;
            preset <= '0;
            count  <= '0;
            out    <= '0;
        end else begin
            state  <= state_next;
            preset <= preset_next;
            count  <= count_next;
            out    <= out_next;
        end
    end

    always_comb begin
        state_next  = state;
        preset_next = preset;
        count_next  = count;
        case (state)
            ST_SET: begin
                if (!forward) begin
                    state_next = ST_LOAD;
                end else if (enable && inc_rise) begin
                    preset_next = (preset == MAX_V) ? '0 : preset + WIDTH'(1);
                end
            end
            ST_LOAD: begin
                count_next = preset;
                state_next = forward ? ST_SET : ST_RUN;
            end
            ST_RUN: begin
                if (forward) begin
                    state_next = ST_SET;
                end else if (enable) begin
                    if (count != '0) begin
                        count_next = count - WIDTH'(1);
                    end else if (minutes != '0) begin
                        // Minutes stage borrows on this same edge.
                        count_next = MAX_V;
                    end else begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                count_next = '0;
                if (forward) begin
                    state_next = ST_SET;
                end
            end
            default: state_next = ST_SET;
        endcase

        // Display tracks the preset while editing or loading, the count otherwise.
        if (state_next == ST_SET || state_next == ST_LOAD) begin
            out_next = preset_next;
        end else begin
            out_next = count_next;
        end
    end

    assign done    = (state == ST_DONE);
    assign running = (state == ST_RUN);

endmodule

// File: tb/tb_seconds_counter_s.sv
// Directed bench for seconds_counter_s with hand-computed expectations.
module tb_seconds_counter_s;

    logic       clk_1Hz = 1'b0;
    logic       reset;
    logic       enable;
    logic       forward;
    logic       increment;
    logic [5:0] minutes;
    logic [5:0] out;
    logic       done;
    logic       running;

    int errors = 0;
    int checks = 0;

    seconds_counter_s dut (
        .clk_1Hz   (clk_1Hz),
        .reset     (reset),
        .enable    (enable),
        .forward   (forward),
        .increment (increment),
        .minutes   (minutes),
        .out       (out),
        .done      (done),
        .running   (running)
    );

    always #5 clk_1Hz = ~clk_1Hz;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_1Hz);
        #1;
    endtask

    task automatic pulse();
        increment = 1'b1;
        step();
        increment = 1'b0;
        step();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        forward = 1'b1;
        enable = 1'b1;
        increment = 1'b0;
        minutes = '0;
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic preset_to(input int n);
        for (int i = 0; i < n; i++) pulse();
    endtask

    initial begin
        // 1: preset and countdown
        do_reset();
        check("rst_out", out, 0);
        check("rst_done", done, 0);
        check("rst_running", running, 0);
        preset_to(5);
        check("t1_preset", out, 5);
        forward = 1'b0;
        step();
        check("t1_load_out", out, 5);
        check("t1_load_running", running, 0);
        step();
        check("t1_run_out", out, 5);
        check("t1_run_running", running, 1);
        for (int v = 4; v >= 0; v--) begin
            step();
            check("t1_count", out, v);
        end
        for (int k = 0; k < 4; k++) begin
            step();
            check("t1_done", done, 1);
            check("t1_done_out", out, 0);
            check("t1_done_running", running, 0);
        end

        // 2: wrap with borrow from minutes
        do_reset();
        preset_to(2);
        minutes = 6'd1;
        forward = 1'b0;
        step();
        check("t2_load", out, 2);
        step();
        check("t2_run2", out, 2);
        check("t2_running", running, 1);
        step();
        check("t2_run1", out, 1);
        step();
        check("t2_run0", out, 0);
        step();
        minutes = 6'd0;
        check("t2_wrap", out, 59);
        check("t2_running_wrap", running, 1);
        step();
        check("t2_run58", out, 58);
        check("t2_running_58", running, 1);
        check("t2_done_low", done, 0);

        // 3: preset wrap and held-high increment
        do_reset();
        for (int i = 1; i <= 60; i++) begin
            pulse();
            check("t3_preset", out, i % 60);
        end
        increment = 1'b1;
        step();
        check("t3_held_first", out, 1);
        for (int k = 0; k < 3; k++) begin
            step();
            check("t3_held", out, 1);
        end
        increment = 1'b0;
        step();
        enable = 1'b0;
        increment = 1'b1;
        step();
        check("t3_disabled_inc", out, 1);
        increment = 1'b0;
        enable = 1'b1;
        step();
        check("t3_not_queued", out, 1);

        // 4: pause
        do_reset();
        preset_to(30);
        forward = 1'b0;
        step();
        step();
        check("t4_run30", out, 30);
        enable = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            check("t4_pause_out", out, 30);
            check("t4_pause_running", running, 1);
        end
        enable = 1'b1;
        step();
        check("t4_resume", out, 29);

        // 5: reset mid-countdown
        do_reset();
        preset_to(17);
        forward = 1'b0;
        step();
        step();
        check("t5_run17", out, 17);
        reset = 1'b0;
        forward = 1'b1;
        step();
        reset = 1'b1;
        check("t5_rst_out", out, 0);
        check("t5_rst_done", done, 0);
        check("t5_rst_running", running, 0);
        pulse();
        check("t5_inc_after_rst", out, 1);

        // 6: forward falls with an increment rise; leave DONE via forward
        forward = 1'b0;
        increment = 1'b1;
        step();
        increment = 1'b0;
        check("t6_load_old_preset", out, 1);
        check("t6_load_running", running, 0);
        step();
        check("t6_run1", out, 1);
        step();
        check("t6_run0", out, 0);
        step();
        check("t6_done", done, 1);
        forward = 1'b1;
        step();
        check("t6_exit_done", done, 0);
        check("t6_exit_out", out, 1);
        check("t6_exit_running", running, 0);

        // Zero preset, zero minutes: LOAD, RUN, then DONE
        do_reset();
        forward = 1'b0;
        step();
        check("z_load", out, 0);
        step();
        check("z_run", running, 1);
        step();
        check("z_done", done, 1);
        check("z_out", out, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
